// File: rtl/riscv_pkg.sv
// Shared RV32 core types: ALU operation codes, hazard struct and divider state encoding.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int DIV_CYCLES = XLEN;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_e;

    typedef struct packed {
        logic load_use;
        logic branch;
        logic division;
    } hazard_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic logic is_div_op(alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divider on operand
// magnitudes, with sign fixup in a final cycle and stall generation for IF/ID/EX.
module div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  alu_op_e         alu_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_e      r_state;
    logic [5:0]      r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_is_div;
    logic            w_signed;
    logic            w_is_rem;
    logic            w_accept;
    logic            w_neg1;
    logic            w_neg2;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_r_shift;
    logic [XLEN:0]   w_r_sub;
    logic            w_ge;
    logic [XLEN-1:0] w_q_fix;
    logic [XLEN-1:0] w_r_fix;

    assign w_is_div = is_div_op(alu_op_i);
    assign w_signed = (alu_op_i == ALU_DIV) || (alu_op_i == ALU_REM);
    assign w_is_rem = (alu_op_i == ALU_REM) || (alu_op_i == ALU_REMU);
    assign w_accept = (r_state == IDLE) && start_i && w_is_div && !flush_i;
    assign w_neg1   = w_signed && rs1_i[XLEN-1];
    assign w_neg2   = w_signed && rs2_i[XLEN-1];
    assign w_div0   = (rs2_i == '0);
    assign w_ovf    = w_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

    // Divide-by-zero and signed overflow results are fixed by the ISA, so no iteration is needed.
    always_comb begin
        w_special_res = '0;
        if (w_div0) begin
            w_special_res = w_is_rem ? rs1_i : '1;
        end else if (!w_is_rem) begin
            w_special_res = rs1_i;
        end
    end

    assign w_r_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_r_sub   = w_r_shift - {1'b0, r_dvs};
    assign w_ge      = (w_r_shift >= {1'b0, r_dvs});
    assign w_q_fix   = neg_if(r_neg_q, r_quo);
    assign w_r_fix   = neg_if(r_neg_r, r_rem[XLEN-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_rem <= w_is_rem;
                        r_neg_q  <= w_neg1 ^ w_neg2;
                        r_neg_r  <= w_neg1;
                        r_dvs    <= neg_if(w_neg2, rs2_i);
                        r_quo    <= neg_if(w_neg1, rs1_i);
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_ge ? w_r_sub : w_r_shift;
                        r_quo <= {r_quo[XLEN-2:0], w_ge};
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == CNT_LAST) begin
                            r_state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (flush_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_result <= r_is_rem ? w_r_fix : w_q_fix;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // DONE deliberately releases the stall so EX/MEM captures result_o this cycle.
    assign stall_o  = w_accept || (r_state == CALC) || (r_state == FIX);
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: latency-level behavioural model checked every cycle, plus
// hand-computed result/latency literals for each directed vector.
module tb_div_unit;
    import riscv_pkg::*;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start_i  = 1'b0;
    logic        flush_i  = 1'b0;
    alu_op_e     alu_op_i = ALU_ADD;
    logic [31:0] rs1_i    = '0;
    logic [31:0] rs2_i    = '0;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] lit_exp   = '0;
    int          lit_lat   = 0;
    bit          lit_valid = 1'b0;

    bit          m_active = 1'b0;
    int          m_pos    = 0;
    int          m_lat    = 0;
    logic [31:0] m_res    = '0;
    logic [31:0] m_held   = '0;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    function automatic bit tb_is_div(input alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic bit tb_special(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (op == ALU_DIV) || (op == ALU_REM);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics; SV signed division truncates toward zero like the ISA.
    function automatic logic [31:0] ref_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        bit        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            ALU_REMU: return (b == 0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit          in_done;
        bit          acc;
        logic [31:0] e_res;
        if (rst) begin
            m_active = 1'b0;
            m_held   = '0;
        end else begin
            in_done = m_active && (m_pos == m_lat);
            acc     = !m_active && start_i && tb_is_div(alu_op_i) && !flush_i;
            e_res   = in_done ? m_res : m_held;
            chk("done_o",   32'(done_o),  32'(in_done));
            chk("busy_o",   32'(busy_o),  32'(m_active));
            chk("stall_o",  32'(stall_o), 32'(acc || (m_active && m_pos < m_lat)));
            chk("result_o", result_o, e_res);
            if (in_done && lit_valid) begin
                chk("lit_result",  result_o, lit_exp);
                chk("lit_latency", 32'(m_lat), 32'(lit_lat));
            end
            if (m_active) begin
                if (in_done) begin
                    m_active = 1'b0;
                    m_held   = m_res;
                end else if (flush_i) begin
                    m_active = 1'b0;
                end else begin
                    m_pos++;
                end
            end else if (acc) begin
                m_active = 1'b1;
                m_pos    = 1;
                m_lat    = tb_special(alu_op_i, rs1_i, rs2_i) ? 1 : 34;
                m_res    = ref_op(alu_op_i, rs1_i, rs2_i);
            end
        end
    end

    task automatic run_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input int lat, input bit hold);
        @(posedge clk); #1;
        alu_op_i  = op;
        rs1_i     = a;
        rs2_i     = b;
        start_i   = 1'b1;
        lit_exp   = lit;
        lit_lat   = lat;
        lit_valid = 1'b1;
        if (hold) begin
            repeat (lat + 1) @(posedge clk);
            #1 start_i = 1'b0;
        end else begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        repeat (lat + 3) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run_op(ALU_DIV,  32'd100,        32'd7,          32'd14,         34, 1'b0);
        run_op(ALU_REM,  32'd100,        32'd7,          32'd2,          34, 1'b0);
        run_op(ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 1'b0);
        run_op(ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 1'b0);
        run_op(ALU_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          34, 1'b0);
        run_op(ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, 1'b0);
        run_op(ALU_DIVU, 32'd5,          32'd10,         32'd0,          34, 1'b0);
        run_op(ALU_REMU, 32'd5,          32'd10,         32'd5,          34, 1'b0);
        run_op(ALU_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         34, 1'b0);
        run_op(ALU_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 1'b0);
        run_op(ALU_DIV,  32'd1234,       32'd0,          32'hFFFF_FFFF,  1,  1'b0);
        run_op(ALU_REM,  32'd1234,       32'd0,          32'd1234,       1,  1'b0);
        run_op(ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0);
        run_op(ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0);

        // Flush in cycle 10 aborts; result_o must keep the previous value.
        @(posedge clk); #1;
        lit_valid = 1'b0;
        alu_op_i  = ALU_DIV;
        rs1_i     = 32'd1000;
        rs2_i     = 32'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        repeat (40) @(posedge clk);
        run_op(ALU_DIV, 32'd9, 32'd3, 32'd3, 34, 1'b0);

        // Reset in cycle 20 of an operation.
        @(posedge clk); #1;
        lit_valid = 1'b0;
        alu_op_i  = ALU_DIVU;
        rs1_i     = 32'd12345;
        rs2_i     = 32'd7;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Non-divide op and a flushed divide request must not start the unit.
        @(posedge clk); #1;
        alu_op_i = ALU_ADD;
        rs1_i    = 32'd50;
        rs2_i    = 32'd5;
        start_i  = 1'b1;
        repeat (4) @(posedge clk);
        #1 alu_op_i = ALU_DIV;
        flush_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 start_i = 1'b0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk);

        // start_i held high through DONE yields a single result.
        run_op(ALU_DIVU, 32'd1000, 32'd10, 32'd100, 34, 1'b1);
        run_op(ALU_REMU, 32'd1000, 32'd7,  32'd6,   34, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
